two_phase_latch_clkgen: RTL and testbench
=========================================

// Module: two_phase_latch_clkgen
// PURPOSE
//  Generates two non-overlapping latch-enable phases (phi1/phi2) from the single system clock.
//  It sits directly upstream of the dlatch stages and drives their clk (enable) inputs.
//  Phase width and dead-time are programmable in system-clock cycles, so the delay and
//  transparency of the latch pipeline can be exercised without glitches or phase overlap.
// PARAMETERS
//  CNT_W    8   width of high_cycles/gap_cycles and of the internal phase counter
//  PCNT_W  16   width of the completed-period counter period_cnt
// PORTS
//  clk          in   1        system clock; all state updates on posedge clk
//  rst          in   1        synchronous reset, active-high
//  en           in   1        run request; sampled on posedge clk
//  high_cycles  in   CNT_W    requested phase-high width H_req, in clk cycles
//  gap_cycles   in   CNT_W    requested non-overlap dead-time G_req, in clk cycles
//  phi1         out  1        phase-1 latch enable (registered)
//  phi2         out  1        phase-2 latch enable (registered)
//  busy         out  1        1 while state != IDLE
//  period_done  out  1        one-cycle pulse on the last cycle of every full period
//  period_cnt   out  PCNT_W   number of completed periods, wraps modulo 2^PCNT_W
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst), sampled on posedge clk only.
//  - Reset values: state=IDLE, phi1=0, phi2=0, busy=0, period_done=0, period_cnt=0, phase counter=0.
//  - FSM states: IDLE -> PHI1 -> GAP1 -> PHI2 -> GAP2 -> (PHI1 | IDLE).
//  - Effective widths: H = (H_req==0) ? 1 : H_req; G = (G_req==0) ? 1 : G_req.
//    H and G are captured in internal registers on every entry into PHI1.
//    Input changes at any other time take effect only from the next period.
//  - IDLE: phi1=phi2=0. When en=1 at edge k, enter PHI1 at edge k; phi1=1 in the following cycle.
//  - PHI1: phi1=1 for exactly H cycles, then GAP1.
//  - GAP1: phi1=phi2=0 for exactly G cycles, then PHI2.
//  - PHI2: phi2=1 for exactly H cycles, then GAP2.
//  - GAP2: both low for exactly G cycles.
//    period_done=1 during the last GAP2 cycle; period_cnt increments at the edge leaving GAP2.
//    Leaving GAP2 with en=1 goes to PHI1 and re-captures H and G; with en=0 it goes to IDLE.
//  - Period length = 2H+2G cycles.
//  - en=0 mid-period does not truncate: the current period completes, then the FSM returns to IDLE.
//  - busy=1 in every state except IDLE. busy is registered together with the state.
//  - Invariants:
//    - phi1 & phi2 is never 1.
//    - At least G (>=1) all-low cycles separate every phi1 fall from the next phi2 rise, and vice versa.
//    - No output changes except on posedge clk.
//  - rst=1 in any state (for example mid-PHI2) forces all reset values at that edge.
//    phi1/phi2 drop to 0 in the next cycle and the partial period is not counted.
//  - period_cnt at 2^PCNT_W-1 wraps to 0 on the next completed period; there is no saturation or flag.
// TESTING
//  1 rst held 3 cycles with en=1 -> phi1=phi2=busy=period_done=0, period_cnt=0 throughout.
//  2 H_req=3, G_req=1, en=1 held ->
//      phi1 high 3 cycles, 1 cycle low, phi2 high 3 cycles, 1 cycle low;
//      period=8 cycles; period_done once per 8 cycles; period_cnt=1,2,3.
//  3 H_req=0, G_req=0 -> treated as H=G=1: phi1,0,phi2,0 repeating with period 4; phi1&phi2 never 1.
//  4 H_req=4, G_req=2; drop en during the 2nd cycle of PHI2 ->
//      PHI2 and GAP2 complete; busy falls after period_done; period_cnt=1; IDLE held.
//  5 Change H_req 2->5 during GAP1 ->
//      current PHI2 still 2 cycles wide; next period's phi1 and phi2 are 5 cycles wide.
//  6 rst pulse in the 2nd cycle of PHI2 ->
//      phi2=0 and busy=0 from the next cycle; period_cnt=0;
//      a fresh period starts cleanly when rst is released with en=1.
//  7 PCNT_W=4, run 17 periods -> period_cnt wraps 15->0 and then reads 1.
//  Bench: continuous assertion !(phi1&phi2); drive latches with phi1/phi2 and check d->q transparency.

Source files
------------

// File: rtl/two_phase_latch_clkgen.sv
// two_phase_latch_clkgen
//   Derives two non-overlapping latch-enable phases (phi1/phi2) from the
//   system clock. Each period is PHI1 (H cycles) -> GAP1 (G cycles) ->
//   PHI2 (H cycles) -> GAP2 (G cycles). Both H and G are programmable, and
//   a zero request is treated as 1.
//
// Ports
//   clk          system clock; all state changes on posedge
//   rst          synchronous reset, active-high
//   en           run request; a started period always runs to completion
//   high_cycles  requested phase-high width (0 is treated as 1)
//   gap_cycles   requested dead-time between phases (0 is treated as 1)
//   phi1, phi2   registered latch enables, never high together
//   busy         high whenever the FSM is not idle
//   period_done  single-cycle pulse on the last GAP2 cycle of each period
//   period_cnt   number of completed periods, wraps modulo 2^PCNT_W
module two_phase_latch_clkgen #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic [CNT_W-1:0]  gap_cycles,
  output logic              phi1,
  output logic              phi2,
  output logic              busy,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PHI1 = 3'd1,
    GAP1 = 3'd2,
    PHI2 = 3'd3,
    GAP2 = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   h_reg, h_next;
  logic [CNT_W-1:0]   g_reg, g_next;
  logic               phi1_reg, phi1_next;
  logic               phi2_reg, phi2_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [PCNT_W-1:0]  pcnt_reg, pcnt_next;

  // Zero requests are promoted to one cycle so a phase or gap is never empty.
  logic [CNT_W-1:0]   h_eff, g_eff;
  assign h_eff = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
  assign g_eff = (gap_cycles  == '0) ? CNT_W'(1) : gap_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      h_reg     <= CNT_W'(1);
      g_reg     <= CNT_W'(1);
      phi1_reg  <= 1'b0;
      phi2_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      pcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      h_reg     <= h_next;
      g_reg     <= g_next;
      phi1_reg  <= phi1_next;
      phi2_reg  <= phi2_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      pcnt_reg  <= pcnt_next;
    end
  end

  // cnt_reg holds the number of cycles remaining in the current state minus
  // one. Every output is computed for the cycle after the edge, so the
  // outputs leave the flops already aligned with the state they describe.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    h_next     = h_reg;
    g_next     = g_reg;
    phi1_next  = phi1_reg;
    phi2_next  = phi2_reg;
    done_next  = 1'b0;
    pcnt_next  = pcnt_reg;

    case (state_reg)
      IDLE: begin
        phi1_next = 1'b0;
        phi2_next = 1'b0;
        if (en) begin
          state_next = PHI1;
          h_next     = h_eff;
          g_next     = g_eff;
          cnt_next   = h_eff - CNT_W'(1);
          phi1_next  = 1'b1;
        end
      end
      PHI1: begin
        if (cnt_reg == '0) begin
          state_next = GAP1;
          cnt_next   = g_reg - CNT_W'(1);
          phi1_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP1: begin
        if (cnt_reg == '0) begin
          state_next = PHI2;
          cnt_next   = h_reg - CNT_W'(1);
          phi2_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      PHI2: begin
        if (cnt_reg == '0) begin
          state_next = GAP2;
          cnt_next   = g_reg - CNT_W'(1);
          phi2_next  = 1'b0;
          // A one-cycle gap makes the first GAP2 cycle also the last one.
          done_next  = (g_reg == CNT_W'(1));
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP2: begin
        if (cnt_reg == '0) begin
          pcnt_next = pcnt_reg + PCNT_W'(1);
          if (en) begin
            state_next = PHI1;
            h_next     = h_eff;
            g_next     = g_eff;
            cnt_next   = h_eff - CNT_W'(1);
            phi1_next  = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next  = cnt_reg - CNT_W'(1);
          done_next = (cnt_reg == CNT_W'(1));
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        phi1_next  = 1'b0;
        phi2_next  = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign phi1        = phi1_reg;
  assign phi2        = phi2_reg;
  assign busy        = busy_reg;
  assign period_done = done_reg;
  assign period_cnt  = pcnt_reg;

endmodule

// File: tb/tb_two_phase_latch_clkgen.sv
// Bench for two_phase_latch_clkgen. A reference model expands each period
// into a list of per-cycle output values that is built from H and G. The
// bench compares every cycle against that list, and it also drives a pair
// of latches from phi1/phi2 to confirm d->q transparency.
module tb_two_phase_latch_clkgen;

  localparam int CNT_W  = 8;
  localparam int PCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [CNT_W-1:0]  high_cycles = '0;
  logic [CNT_W-1:0]  gap_cycles  = '0;
  logic              phi1, phi2, busy, period_done;
  logic [PCNT_W-1:0] period_cnt;

  int tests = 0;
  int fails = 0;

  two_phase_latch_clkgen #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .high_cycles(high_cycles), .gap_cycles(gap_cycles),
    .phi1(phi1), .phi2(phi2), .busy(busy),
    .period_done(period_done), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  // Latch chain driven by the generated phases.
  logic [7:0] d = '0, q1, q2;
  always_latch begin
    if (phi1) q1 <= d;
  end
  always_latch begin
    if (phi2) q2 <= q1;
  end

  // Reference model: a period is a list of (phi1, phi2, done) cycles.
  typedef struct packed { bit p1; bit p2; bit done; } cyc_t;
  cyc_t              q[$];
  bit                running = 0;
  bit                exp_p1 = 0, exp_p2 = 0, exp_done = 0, exp_busy = 0;
  logic [PCNT_W-1:0] exp_cnt = '0;

  task automatic build_period(input int hr, input int gr);
    int h, g;
    h = (hr == 0) ? 1 : hr;
    g = (gr == 0) ? 1 : gr;
    for (int i = 0; i < h; i++) q.push_back('{1'b1, 1'b0, 1'b0});
    for (int i = 0; i < g; i++) q.push_back('{1'b0, 1'b0, 1'b0});
    for (int i = 0; i < h; i++) q.push_back('{1'b0, 1'b1, 1'b0});
    for (int i = 0; i < g; i++) q.push_back('{1'b0, 1'b0, (i == g - 1)});
  endtask

  always @(posedge clk) begin
    cyc_t c;
    if (rst) begin
      q.delete();
      running = 0;
      exp_cnt = '0;
      {exp_p1, exp_p2, exp_done} = 3'b000;
    end else begin
      if (q.size() == 0) begin
        if (running) exp_cnt = exp_cnt + 1'b1;
        running = 0;
        if (en) begin
          build_period(int'(high_cycles), int'(gap_cycles));
          running = 1;
        end
      end
      if (q.size() != 0) begin
        c = q.pop_front();
        {exp_p1, exp_p2, exp_done} = {c.p1, c.p2, c.done};
      end else begin
        {exp_p1, exp_p2, exp_done} = 3'b000;
      end
    end
    exp_busy = running;
  end

  // Non-overlap invariant, checked away from the clock edge.
  always @(negedge clk) begin
    tests++;
    assert (!(phi1 && phi2)) else begin
      fails++;
      $error("FAIL overlap phi1=%0b phi2=%0b required not both 1", phi1, phi2);
    end
  end

  int cyc_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, expv);
    end
  endtask

  // Advance one clock (inputs already set), then check on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    chk("phi1", phi1, exp_p1);
    chk("phi2", phi2, exp_p2);
    chk("busy", busy, exp_busy);
    chk("period_done", period_done, exp_done);
    chk("period_cnt", period_cnt, exp_cnt);
    if (phi1) chk("latch1_transparent", q1, d);
    if (phi2) chk("latch2_transparent", q2, q1);
    $display("[TB] cyc=%0d rst=%0b en=%0b H=%0d G=%0d phi1=%0b phi2=%0b busy=%0b done=%0b cnt=%0d",
             cyc_no, rst, en, high_cycles, gap_cycles, phi1, phi2, busy, period_done, period_cnt);
    d = 8'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Step until phi2 is observed high, bounded by a cycle budget.
  task automatic wait_phi2(input int budget);
    int k = 0;
    while (phi2 !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    tests++;
    if (phi2 !== 1'b1) begin
      fails++;
      $display("FAIL wait_phi2 observed timeout after %0d cycles required phi2=1", budget);
    end
  endtask

  task automatic wait_phi1_fall(input int budget);
    int k = 0;
    while (phi1 !== 1'b1 && k < budget) begin cyc(); k++; end
    while (phi1 !== 1'b0 && k < budget) begin cyc(); k++; end
    tests++;
    if (k >= budget) begin
      fails++;
      $display("FAIL wait_phi1_fall observed timeout after %0d cycles required phi1 fall", budget);
    end
  endtask

  int dones;

  initial begin
    // 1: reset held with en=1
    rst = 1; en = 1; high_cycles = 3; gap_cycles = 1;
    run(3);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cnt", period_cnt, '0);

    // 2: H=3 G=1, three full periods of 8 cycles
    rst = 0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (period_done) dones++;
    end
    chk("t2_period_cnt", period_cnt, 4'd3);
    chk("t2_done_pulses", dones, 3);
    chk("t2_new_phi1", phi1, 1'b1);

    // 3: H=G=0 behaves as 1, period 4
    rst = 1; run(1); rst = 0;
    high_cycles = 0; gap_cycles = 0;
    run(17);
    chk("t3_period_cnt", period_cnt, 4'd4);

    // 4: H=4 G=2, drop en in 2nd PHI2 cycle
    rst = 1; run(1); rst = 0;
    high_cycles = 4; gap_cycles = 2;
    wait_phi2(40);
    en = 0;
    run(12);
    chk("t4_idle_busy", busy, 1'b0);
    chk("t4_period_cnt", period_cnt, 4'd1);
    en = 1;

    // 5: change H 2->5 during GAP1
    rst = 1; run(1); rst = 0;
    high_cycles = 2; gap_cycles = 1;
    wait_phi1_fall(40);
    high_cycles = 5;
    run(20);

    // 6: reset in 2nd PHI2 cycle, then clean restart
    wait_phi2(40);
    rst = 1;
    cyc();
    chk("t6_phi2", phi2, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cnt", period_cnt, '0);
    rst = 0;
    run(20);

    // 7: wrap of a 4-bit period counter
    rst = 1; run(1); rst = 0;
    high_cycles = 0; gap_cycles = 0;
    run(65);
    chk("t7_wrap0", period_cnt, 4'd0);
    run(4);
    chk("t7_wrap1", period_cnt, 4'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) high_cycles = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) gap_cycles  = CNT_W'($urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
